// File: rtl/iccm_mem.sv
// Instruction closely-coupled memory.
// Fetch port: one 32-bit word per cycle, registered read data one cycle after
// the address. Load port: byte-serial, little-endian word assembly, words
// written at an auto-incrementing address by a small IDLE/COLLECT/WRITE/DONE FSM.
//
// Load-port handshake: a byte transfers on a rising clock edge where
// ld_byte_valid and ld_byte_ready are both high. ld_byte_ready is high only in
// COLLECT and depends on registered state alone. ld_byte and ld_last are only
// meaningful while ld_byte_valid is high. The fetch port has no handshake: a
// read is issued every cycle iccm_rd_en is high.
module iccm_mem #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iccm_rd_addr,
  input  logic        iccm_rd_en,
  output logic [31:0] iccm_rd_data,
  input  logic        ld_start,
  input  logic [31:0] ld_base_addr,
  input  logic        ld_byte_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_byte_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [15:0] ld_word_cnt,
  output logic        ld_err
);

  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // The array stores word XOR INIT_WORD, so a zero power-up image reads back
  // as INIT_WORD (NOP) everywhere without any fill logic.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [1:0]  byte_ptr_q, byte_ptr_d;
  logic [31:0] shift_q, shift_d;
  logic        last_q, last_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        err_q, err_d;
  logic [31:0] rd_data_q, rd_data_d;

  // Address decode for both ports. An address below BASE_ADDR wraps to a
  // large offset and so falls out of range as well.
  logic [31:0]     rd_off, w_off;
  logic            rd_in_range, w_in_range;
  logic [IDXW-1:0] rd_idx, w_idx;
  logic            mem_we;

  assign rd_off      = iccm_rd_addr - BASE_ADDR;
  assign w_off       = waddr_q - BASE_ADDR;
  assign rd_in_range = {1'b0, rd_off} < SPAN;
  assign w_in_range  = {1'b0, w_off} < SPAN;
  assign rd_idx      = rd_off[IDXW+1:2];
  assign w_idx       = w_off[IDXW+1:2];
  assign mem_we      = (state_q == ST_WRITE) && w_in_range;

  // Load FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    byte_ptr_d = byte_ptr_q;
    shift_d    = shift_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          waddr_d    = ld_base_addr;
          byte_ptr_d = 2'd0;
          shift_d    = 32'h0;
          last_d     = 1'b0;
          word_cnt_d = 16'h0;
          err_d      = 1'b0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (ld_byte_valid) begin
          shift_d[{byte_ptr_q, 3'b000} +: 8] = ld_byte;
          byte_ptr_d = byte_ptr_q + 2'd1;
          last_d     = ld_last;
          if ((byte_ptr_q == 2'd3) || ld_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!w_in_range) err_d = 1'b1;
        waddr_d    = waddr_q + 32'd4;
        word_cnt_d = word_cnt_q + 16'd1;
        shift_d    = 32'h0;
        byte_ptr_d = 2'd0;
        state_d    = last_q ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch read: out-of-range returns zero, a same-cycle write to the same word
  // is forwarded, and the output holds while rd_en is low.
  always_comb begin
    rd_data_d = rd_data_q;
    if (iccm_rd_en) begin
      if (!rd_in_range)                 rd_data_d = 32'h0;
      else if (mem_we && w_idx == rd_idx) rd_data_d = shift_q;
      else                              rd_data_d = mem_q[rd_idx] ^ INIT_WORD;
    end
  end

  // Control and read-data registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waddr_q    <= 32'h0;
      byte_ptr_q <= 2'd0;
      shift_q    <= 32'h0;
      last_q     <= 1'b0;
      word_cnt_q <= 16'h0;
      err_q      <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      byte_ptr_q <= byte_ptr_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[w_idx] <= shift_q ^ INIT_WORD;
  end

  assign iccm_rd_data  = rd_data_q;
  assign ld_byte_ready = (state_q == ST_COLLECT);
  assign ld_busy       = (state_q != ST_IDLE);
  assign ld_done       = (state_q == ST_DONE);
  assign ld_word_cnt   = word_cnt_q;
  assign ld_err        = err_q;

endmodule
